control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 152 +++++++++++++++
 tb/tb_control_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hard-wired sequencer for the 32-bit CPU: fetch T0..T2, per-opcode execute T3..T7.
// Stop or the halt opcode lets the current instruction finish, then parks in HALT until Clear.
module control_unit (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout, RINout, OutPortOut,
    output logic        PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, OutPortIn, CONin, RAin,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output logic        Read, Write, IncPC,
    output logic        ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8,  OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18, OP_BR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20, OP_JR   = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24, OP_MFHI = 5'd25, OP_NOP  = 5'd26, OP_HALT = 5'd27;

    state_t     state, nxt;
    logic [4:0] op_q, ir_op;
    logic       stop_pend, last;
    logic       unused_ir;

    // Operand fields are consumed by the datapath, not the sequencer.
    assign unused_ir = ^IR[26:0];
    assign ir_op     = (IR[31:27] > OP_HALT) ? OP_NOP : IR[31:27];

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state     <= S_RESET;
            stop_pend <= 1'b0;
            op_q      <= OP_NOP;
        end else begin
            state <= nxt;
            if (Stop)          stop_pend <= 1'b1;
            if (state == S_T2) op_q      <= ir_op;
        end
    end

    always_comb begin
        case (op_q)
            OP_LD:                           last = (state == S_T7);
            OP_ST, OP_MUL, OP_DIV, OP_BR:    last = (state == S_T6);
            OP_NEG, OP_NOT, OP_JAL:          last = (state == S_T4);
            OP_JR, OP_IN, OP_OUT, OP_MFLO,
            OP_MFHI, OP_NOP, OP_HALT:        last = (state == S_T3);
            default:                         last = (state == S_T5);
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            S_RESET: nxt = S_T0;
            S_T0:    nxt = S_T1;
            S_T1:    nxt = S_T2;
            S_T2:    nxt = (ir_op == OP_HALT) ? S_HALT : S_T3;
            S_T3:    nxt = S_T4;
            S_T4:    nxt = S_T5;
            S_T5:    nxt = S_T6;
            S_T6:    nxt = S_T7;
            S_T7:    nxt = S_T0;
            S_HALT:  nxt = S_HALT;
            default: nxt = S_RESET;
        endcase
        // Any execute state may be the last one; a pending Stop diverts the refetch into HALT.
        if (state inside {S_T3, S_T4, S_T5, S_T6, S_T7} && last)
            nxt = (stop_pend || Stop) ? S_HALT : S_T0;
    end

    always_comb begin
        {PCout, Zlowout, Zhighout, MDRout, LOout, HIout, RINout, OutPortOut} = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, OutPortIn, CONin, RAin} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout, Read, Write, IncPC} = '0;
        {ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT} = '0;
        Run = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: case (op_q)
                OP_LD, OP_LDI, OP_ST:    begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                OP_MUL, OP_DIV:          begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                OP_BR:                   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                OP_NEG:                  begin Grb = 1'b1; Rout = 1'b1; NEG = 1'b1; Zin = 1'b1; end
                OP_NOT:                  begin Grb = 1'b1; Rout = 1'b1; NOT = 1'b1; Zin = 1'b1; end
                OP_JR:                   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                OP_JAL:                  begin PCout = 1'b1; RAin = 1'b1; end
                OP_IN:                   begin RINout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_OUT:                  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
                OP_MFLO:                 begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_MFHI:                 begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_NOP, OP_HALT:         ;
                default:                 begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            endcase
            S_T4: begin
                case (op_q)
                    OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST: ADD = 1'b1;
                    OP_SUB:           SUB  = 1'b1;
                    OP_AND, OP_ANDI:  AND  = 1'b1;
                    OP_OR, OP_ORI:    OR   = 1'b1;
                    OP_ROR:           ROR  = 1'b1;
                    OP_ROL:           ROL  = 1'b1;
                    OP_SHR:           SHR  = 1'b1;
                    OP_SHRA:          SHRA = 1'b1;
                    OP_SHL:           SHL  = 1'b1;
                    OP_MUL:           MUL  = 1'b1;
                    OP_DIV:           DIV  = 1'b1;
                    default:          ;
                endcase
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
                                             begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LD, OP_LDI, OP_ST:
                                             begin Cout = 1'b1; Zin = 1'b1; end
                    OP_MUL, OP_DIV:          begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                    OP_BR:                   begin PCout = 1'b1; Yin = 1'b1; end
                    OP_NEG, OP_NOT:          begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_JAL:                  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default:                 ;
                endcase
            end
            S_T5: case (op_q)
                OP_LD, OP_ST:            begin Zlowout = 1'b1; MARin = 1'b1; end
                OP_MUL, OP_DIV:          begin Zlowout = 1'b1; LOin = 1'b1; end
                OP_BR:                   begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
                OP_SHL, OP_ADDI, OP_ANDI, OP_ORI:
                                         begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default:                 ;
            endcase
            S_T6: case (op_q)
                OP_LD:                   begin Read = 1'b1; MDRin = 1'b1; end
                OP_ST:                   begin Gra = 1'b1; Rout = 1'b1; Write = 1'b1; end
                OP_MUL, OP_DIV:          begin Zhighout = 1'b1; HIin = 1'b1; end
                OP_BR:                   begin Zlowout = CON_FF; PCin = CON_FF; end
                default:                 ;
            endcase
            S_T7: if (op_q == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, hand-written multi-cycle corners and random
// instruction streams compared cycle by cycle against a per-opcode control-word table model.
module tb_control_unit;
    typedef logic [42:0] vec_t;
    localparam vec_t B_RUN = 43'd1 << 0,  B_PCOUT = 43'd1 << 1,  B_ZLOWOUT = 43'd1 << 2;
    localparam vec_t B_ZHIGHOUT = 43'd1 << 3, B_MDROUT = 43'd1 << 4, B_LOOUT = 43'd1 << 5;
    localparam vec_t B_HIOUT = 43'd1 << 6, B_RINOUT = 43'd1 << 7, B_OUTPORTOUT = 43'd1 << 8;
    localparam vec_t B_PCIN = 43'd1 << 9, B_IRIN = 43'd1 << 10, B_MARIN = 43'd1 << 11;
    localparam vec_t B_MDRIN = 43'd1 << 12, B_YIN = 43'd1 << 13, B_ZIN = 43'd1 << 14;
    localparam vec_t B_LOIN = 43'd1 << 15, B_HIIN = 43'd1 << 16, B_OUTPORTIN = 43'd1 << 17;
    localparam vec_t B_CONIN = 43'd1 << 18, B_RAIN = 43'd1 << 19, B_GRA = 43'd1 << 20;
    localparam vec_t B_GRB = 43'd1 << 21, B_GRC = 43'd1 << 22, B_RIN = 43'd1 << 23;
    localparam vec_t B_ROUT = 43'd1 << 24, B_BAOUT = 43'd1 << 25, B_COUT = 43'd1 << 26;
    localparam vec_t B_READ = 43'd1 << 27, B_WRITE = 43'd1 << 28, B_INCPC = 43'd1 << 29;
    localparam vec_t A_ADD = 43'd1 << 30, A_SUB = 43'd1 << 31, A_MUL = 43'd1 << 32;
    localparam vec_t A_DIV = 43'd1 << 33, A_SHR = 43'd1 << 34, A_SHRA = 43'd1 << 35;
    localparam vec_t A_SHL = 43'd1 << 36, A_ROR = 43'd1 << 37, A_ROL = 43'd1 << 38;
    localparam vec_t A_AND = 43'd1 << 39, A_OR = 43'd1 << 40, A_NEG = 43'd1 << 41;
    localparam vec_t A_NOT = 43'd1 << 42;
    localparam vec_t T0_VEC = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN;

    logic Clock, Clear, CON_FF, Stop, Run;
    logic [31:0] IR;
    logic PCout, Zlowout, Zhighout, MDRout, LOout, HIout, RINout, OutPortOut;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, OutPortIn, CONin, RAin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Read, Write, IncPC;
    logic ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .LOout(LOout), .HIout(HIout), .RINout(RINout), .OutPortOut(OutPortOut),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .LOin(LOin), .HIin(HIin), .OutPortIn(OutPortIn), .CONin(CONin), .RAin(RAin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .Read(Read), .Write(Write), .IncPC(IncPC),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHRA(SHRA), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEG(NEG), .NOT(NOT)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    vec_t act;
    always_comb begin
        act = '0;
        if (Run) act |= B_RUN;          if (PCout) act |= B_PCOUT;
        if (Zlowout) act |= B_ZLOWOUT;  if (Zhighout) act |= B_ZHIGHOUT;
        if (MDRout) act |= B_MDROUT;    if (LOout) act |= B_LOOUT;
        if (HIout) act |= B_HIOUT;      if (RINout) act |= B_RINOUT;
        if (OutPortOut) act |= B_OUTPORTOUT;
        if (PCin) act |= B_PCIN;        if (IRin) act |= B_IRIN;
        if (MARin) act |= B_MARIN;      if (MDRin) act |= B_MDRIN;
        if (Yin) act |= B_YIN;          if (Zin) act |= B_ZIN;
        if (LOin) act |= B_LOIN;        if (HIin) act |= B_HIIN;
        if (OutPortIn) act |= B_OUTPORTIN;
        if (CONin) act |= B_CONIN;      if (RAin) act |= B_RAIN;
        if (Gra) act |= B_GRA;          if (Grb) act |= B_GRB;
        if (Grc) act |= B_GRC;          if (Rin) act |= B_RIN;
        if (Rout) act |= B_ROUT;        if (BAout) act |= B_BAOUT;
        if (Cout) act |= B_COUT;        if (Read) act |= B_READ;
        if (Write) act |= B_WRITE;      if (IncPC) act |= B_INCPC;
        if (ADD) act |= A_ADD;          if (SUB) act |= A_SUB;
        if (MUL) act |= A_MUL;          if (DIV) act |= A_DIV;
        if (SHR) act |= A_SHR;          if (SHRA) act |= A_SHRA;
        if (SHL) act |= A_SHL;          if (ROR) act |= A_ROR;
        if (ROL) act |= A_ROL;          if (AND) act |= A_AND;
        if (OR) act |= A_OR;            if (NEG) act |= A_NEG;
        if (NOT) act |= A_NOT;
    end

    // Model: each instruction is the 3-step fetch followed by its table of execute control words.
    vec_t fetch_w [3];
    vec_t tab [32][5];
    int   tlen [32];
    int   m_state;     // 0 reset, 1 running, 2 halted
    int   m_idx;       // cycle index within the current instruction, 0 = T0
    logic m_pend;
    int   tests, fails;

    task automatic put(input int op, input int n, input vec_t a, input vec_t b,
                       input vec_t c, input vec_t d, input vec_t e);
        tlen[op] = n;
        tab[op][0] = a; tab[op][1] = b; tab[op][2] = c; tab[op][3] = d; tab[op][4] = e;
    endtask

    function automatic vec_t exp_now();
        logic [4:0] op;
        vec_t v;
        op = IR[31:27];
        if (m_state != 1) return '0;
        if (m_idx < 3) return fetch_w[m_idx] | B_RUN;
        v = tab[op][m_idx - 3];
        if (op == 5'd19 && m_idx == 6 && !CON_FF) v = '0;
        return v | B_RUN;
    endfunction

    task automatic check(input string nm, input vec_t a, input vec_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Advance the model by the edge about to happen, then sample just after it.
    task automatic tick();
        logic [4:0] op;
        op = IR[31:27];
        if (Clear) begin
            m_state = 0; m_pend = 1'b0;
        end else if (m_state == 0) begin
            m_state = 1; m_idx = 0;
        end else if (m_state == 1) begin
            if (Stop) m_pend = 1'b1;
            m_idx++;
            if (m_idx == 3 + tlen[op]) begin
                if (op == 5'd27 || m_pend) m_state = 2;
                else m_idx = 0;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic step(input string nm);
        tick();
        check(nm, act, exp_now());
    endtask

    task automatic do_clear();
        Clear = 1'b1; Stop = 1'b0;
        step("clear");
        check("reset_zero", act, '0);
        Clear = 1'b0;
        step("to_t0");
    endtask

    typedef struct {
        logic [31:0] ir;
        logic        con;
        int          len;
        int          at;
        vec_t        v;
    } vrec_t;
    vrec_t vt [15];

    initial begin
        vec_t alu_rr [3:11];
        tests = 0; fails = 0;
        Clear = 1'b1; Stop = 1'b0; CON_FF = 1'b0; IR = 32'hD000_0000;
        m_state = 0; m_idx = 0; m_pend = 1'b0;

        fetch_w[0] = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
        fetch_w[1] = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
        fetch_w[2] = B_MDROUT | B_IRIN;
        for (int op = 0; op < 32; op++) put(op, 1, '0, '0, '0, '0, '0);
        alu_rr[3] = A_ADD; alu_rr[4] = A_SUB; alu_rr[5] = A_AND; alu_rr[6] = A_OR;
        alu_rr[7] = A_ROR; alu_rr[8] = A_ROL; alu_rr[9] = A_SHR; alu_rr[10] = A_SHRA;
        alu_rr[11] = A_SHL;
        for (int op = 3; op <= 11; op++)
            put(op, 3, B_GRB | B_ROUT | B_YIN, B_GRC | B_ROUT | alu_rr[op] | B_ZIN,
                B_ZLOWOUT | B_GRA | B_RIN, '0, '0);
        put(12, 3, B_GRB | B_ROUT | B_YIN, B_COUT | A_ADD | B_ZIN, B_ZLOWOUT | B_GRA | B_RIN, '0, '0);
        put(13, 3, B_GRB | B_ROUT | B_YIN, B_COUT | A_AND | B_ZIN, B_ZLOWOUT | B_GRA | B_RIN, '0, '0);
        put(14, 3, B_GRB | B_ROUT | B_YIN, B_COUT | A_OR | B_ZIN, B_ZLOWOUT | B_GRA | B_RIN, '0, '0);
        put(0, 5, B_GRB | B_BAOUT | B_YIN, B_COUT | A_ADD | B_ZIN, B_ZLOWOUT | B_MARIN,
            B_READ | B_MDRIN, B_MDROUT | B_GRA | B_RIN);
        put(1, 3, B_GRB | B_BAOUT | B_YIN, B_COUT | A_ADD | B_ZIN, B_ZLOWOUT | B_GRA | B_RIN, '0, '0);
        put(2, 4, B_GRB | B_BAOUT | B_YIN, B_COUT | A_ADD | B_ZIN, B_ZLOWOUT | B_MARIN,
            B_GRA | B_ROUT | B_WRITE, '0);
        put(15, 4, B_GRA | B_ROUT | B_YIN, B_GRB | B_ROUT | A_DIV | B_ZIN, B_ZLOWOUT | B_LOIN,
            B_ZHIGHOUT | B_HIIN, '0);
        put(16, 4, B_GRA | B_ROUT | B_YIN, B_GRB | B_ROUT | A_MUL | B_ZIN, B_ZLOWOUT | B_LOIN,
            B_ZHIGHOUT | B_HIIN, '0);
        put(17, 2, B_GRB | B_ROUT | A_NEG | B_ZIN, B_ZLOWOUT | B_GRA | B_RIN, '0, '0, '0);
        put(18, 2, B_GRB | B_ROUT | A_NOT | B_ZIN, B_ZLOWOUT | B_GRA | B_RIN, '0, '0, '0);
        put(19, 4, B_GRA | B_ROUT | B_CONIN, B_PCOUT | B_YIN, B_COUT | A_ADD | B_ZIN,
            B_ZLOWOUT | B_PCIN, '0);
        put(20, 2, B_PCOUT | B_RAIN, B_GRA | B_ROUT | B_PCIN, '0, '0, '0);
        put(21, 1, B_GRA | B_ROUT | B_PCIN, '0, '0, '0, '0);
        put(22, 1, B_RINOUT | B_GRA | B_RIN, '0, '0, '0, '0);
        put(23, 1, B_GRA | B_ROUT | B_OUTPORTIN, '0, '0, '0, '0);
        put(24, 1, B_LOOUT | B_GRA | B_RIN, '0, '0, '0, '0);
        put(25, 1, B_HIOUT | B_GRA | B_RIN, '0, '0, '0, '0);
        put(27, 0, '0, '0, '0, '0, '0);

        // {IR, CON_FF, cycles until next T0, cycle index to spot-check, control word there}
        vt[0]  = '{32'h1894_0000, 1'b0, 6, 4, B_RUN | B_GRC | B_ROUT | A_ADD | B_ZIN};
        vt[1]  = '{32'h1894_0000, 1'b0, 6, 1, B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN};
        vt[2]  = '{32'h0080_0055, 1'b0, 8, 6, B_RUN | B_READ | B_MDRIN};
        vt[3]  = '{32'h0080_0055, 1'b0, 8, 7, B_RUN | B_MDROUT | B_GRA | B_RIN};
        vt[4]  = '{32'h9800_0000, 1'b1, 7, 6, B_RUN | B_ZLOWOUT | B_PCIN};
        vt[5]  = '{32'h9800_0000, 1'b0, 7, 6, B_RUN};
        vt[6]  = '{32'h8000_0000, 1'b0, 7, 4, B_RUN | B_GRB | B_ROUT | A_MUL | B_ZIN};
        vt[7]  = '{32'h8000_0000, 1'b0, 7, 6, B_RUN | B_ZHIGHOUT | B_HIIN};
        vt[8]  = '{32'h7800_0000, 1'b0, 7, 5, B_RUN | B_ZLOWOUT | B_LOIN};
        vt[9]  = '{32'h1000_0000, 1'b0, 7, 6, B_RUN | B_GRA | B_ROUT | B_WRITE};
        vt[10] = '{32'hA000_0000, 1'b0, 5, 3, B_RUN | B_PCOUT | B_RAIN};
        vt[11] = '{32'h8800_0000, 1'b0, 5, 3, B_RUN | B_GRB | B_ROUT | A_NEG | B_ZIN};
        vt[12] = '{32'hB000_0000, 1'b0, 4, 3, B_RUN | B_RINOUT | B_GRA | B_RIN};
        vt[13] = '{32'hF800_0000, 1'b0, 4, 3, B_RUN};
        vt[14] = '{32'h7000_0000, 1'b0, 6, 4, B_RUN | B_COUT | A_OR | B_ZIN};

        for (int i = 0; i < 15; i++) begin
            do_clear();
            check("t0_after_clear", act, T0_VEC);
            IR = vt[i].ir; CON_FF = vt[i].con;
            for (int c = 1; c <= vt[i].len; c++) begin
                step("vec_model");
                if (c == vt[i].at) check("vec_word", act, vt[i].v);
            end
            check("vec_refetch", act, T0_VEC);
        end

        // Stop pulsed in T4 of add: T5 still runs, then HALT for good.
        do_clear(); IR = 32'h1894_0000;
        repeat (4) step("stop_seq");
        Stop = 1'b1; step("stop_t5"); Stop = 1'b0;
        check("stop_t5_word", act, B_RUN | B_ZLOWOUT | B_GRA | B_RIN);
        for (int c = 0; c < 20; c++) begin
            step("stop_halt_model");
            check("stop_halt_zero", act, '0);
        end

        // halt opcode: HALT straight after T2.
        do_clear(); IR = 32'hD800_0000;
        step("halt_t1"); step("halt_t2");
        check("halt_t2_word", act, B_RUN | B_MDROUT | B_IRIN);
        for (int c = 0; c < 4; c++) begin
            step("halt_model");
            check("halt_zero", act, '0);
        end

        // Clear during T6 of st aborts the write; Clear held keeps RESET.
        do_clear(); IR = 32'h1000_0000;
        repeat (6) step("st_seq");
        check("st_t6_write", act, B_RUN | B_GRA | B_ROUT | B_WRITE);
        Clear = 1'b1; step("st_clear");
        check("st_clear_zero", act, '0);
        step("st_clear_held");
        check("st_clear_held_zero", act, '0);
        Clear = 1'b0; step("st_release");
        check("st_release_t0", act, T0_VEC);

        // A Stop that is followed by Clear must not halt the next instruction.
        do_clear(); IR = 32'h1894_0000;
        Stop = 1'b1; step("pend_set"); Stop = 1'b0;
        Clear = 1'b1; step("pend_clear"); Clear = 1'b0;
        step("pend_t0");
        repeat (6) step("pend_run");
        check("pend_cleared_refetch", act, T0_VEC);

        // Random instruction stream with sporadic Stop and Clear.
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] opv;
            Stop = 1'b0; Clear = 1'b0;
            if (m_state == 1 && m_idx == 0) begin
                opv = 5'($urandom_range(0, 31));
                if (opv == 5'd27 && $urandom_range(0, 3) != 0) opv = 5'd3;
                IR = {opv, 27'($urandom)};
                CON_FF = 1'($urandom_range(0, 1));
            end
            if (m_state == 1 && $urandom_range(0, 59) == 0) Stop = 1'b1;
            if ($urandom_range(0, 149) == 0 || (m_state == 2 && $urandom_range(0, 7) == 0))
                Clear = 1'b1;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
